load_store_unit: RTL
====================

# load_store_unit

Initiator side of the data-memory interface: it sits between the execute stage and the single-port data memory. It accepts one byte-addressed load or store request at a time and drives MemRead/MemWrite, the word address and the write data. It sign- or zero-extends load data. Byte and half stores are done as read-modify-write, because the memory is word-wide with no byte enables.

## Interface
- DM_ADDRESS, 9, data-memory word-address width
- DATA_W, 32, data width (fixed at 32 for RV32 extraction)
- clk  in  1  clock; memory writes also occur on posedge clk
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; accept = req_valid & req_ready at a rising edge
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  DATA_W  byte address (ALU result)
- req_wdata  in  DATA_W  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned or illegal request, qualified by resp_valid
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable
- a  out  DM_ADDRESS  word address = req_addr[DM_ADDRESS+1:2]
- wd  out  DATA_W  memory write data
- rd  in  DATA_W  memory read data; combinational from a while MemRead=1

## Operation
- FSM states: IDLE, LOAD, WRITE, RMW_READ, RMW_WRITE.
- Acceptance in IDLE registers all request fields. Next state:
  - error → IDLE, with resp_valid set.
  - load → LOAD.
  - SW → WRITE.
  - SB/SH → RMW_READ.
- Error conditions:
  - funct3 is 011, 110 or 111.
  - Store with funct3 100 or 101.
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
- An errored request never asserts MemRead or MemWrite.
- LOAD: MemRead=1. At the edge, the extracted and extended rd is registered into resp_rdata. Next state is IDLE, with resp_valid set.
- Load extraction:
  - B/BU: byte lane addr[1:0].
  - H/HU: half at addr[1].
  - B and H sign-extend; BU and HU zero-extend.
- WRITE: MemWrite=1, wd = wdata. Next state is IDLE, with resp_valid set.
- RMW_READ: MemRead=1. At the edge, rd is registered with the new bytes merged in:
  - SB: wdata[7:0] into lane addr[1:0].
  - SH: wdata[15:0] into half addr[1].
- RMW_WRITE: MemWrite=1, wd = merge register. Next state is IDLE, with resp_valid set.
- MemRead and MemWrite are never high together, and neither is high in IDLE.
- Address bits above DM_ADDRESS+1 are ignored, so addresses wrap modulo 2^(DM_ADDRESS+2) bytes.
- Reset mid-operation aborts the request with no response. A write not yet issued is never issued.

## Timing
- Reset values:
  - state IDLE, req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_error=0.
  - MemRead=0, MemWrite=0, a=0, wd=0.
- Latency, counted from the acceptance edge E0 to the resp_valid cycle:
  - error: 1 cycle (high after E0).
  - load and SW: 2 cycles (high after E1).
  - SB/SH: 3 cycles (high after E2).
- resp_valid is high for exactly one cycle; resp_rdata and resp_error hold until the next response.
- req_ready is high during the resp_valid cycle, so a back-to-back request can be accepted there. Peak throughput is one load every 2 cycles.
- a is held from the acceptance edge until the next acceptance. wd is 0 outside WRITE and RMW_WRITE.
- No combinational path from the req_* inputs to any output. The only combinational input use is rd through the extract and merge logic into registers.

## Structure
- Package lsu_pkg:
  - funct3 width codes as a localparam/enum.
  - FSM state enum.
  - Helper function for the error check.
- Sub-module lsu_align, purely combinational:
  - load extract/extend from (rd, offset, funct3).
  - store merge from (rd, wdata, offset, funct3).
- Top level holds the FSM, request registers and response registers.

## Test plan
- SW addr 0x10 data 0xDEADBEEF:
  - one MemWrite cycle with a=4, wd=0xDEADBEEF.
  - resp_valid 2 cycles after accept, resp_error=0.
  - then LW 0x10 → resp_rdata 0xDEADBEEF.
- Word 0xDEADBEEF at 0x10:
  - LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE.
  - LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- Same word:
  - SB 0x11 data 0x55 → MemRead cycle then MemWrite with wd=0xDEAD55EF; resp 3 cycles after accept.
  - then SH 0x12 data 0x1234 → wd=0x123455EF.
- Errors:
  - LW 0x12, SH 0x13 and funct3 011 each give resp_valid 1 cycle after accept with resp_error=1, resp_rdata=0.
  - MemRead/MemWrite stay 0 throughout.
- rst_n low during RMW_READ of an SB:
  - MemWrite never asserts; the following LW shows the word unchanged.
  - req_ready=1 and all outputs at reset values after the reset edge.
- req_valid held high over 4 alternating LW/SW requests:
  - each new request is accepted in the previous resp_valid cycle.
  - final memory contents and responses match the reference model; address 0x810 aliases word 4.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: RV32 width codes, FSM encodings and
// the request legality check.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] FunctB  = 3'b000;
    localparam logic [2:0] FunctH  = 3'b001;
    localparam logic [2:0] FunctW  = 3'b010;
    localparam logic [2:0] FunctBu = 3'b100;
    localparam logic [2:0] FunctHu = 3'b101;

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StLoad     = 3'd1;
    localparam logic [2:0] StWrite    = 3'd2;
    localparam logic [2:0] StRmwRead  = 3'd3;
    localparam logic [2:0] StRmwWrite = 3'd4;

    // Unsigned widths have no store form; halves need bit 0 clear, words both bits.
    function automatic logic req_error(input logic       write,
                                       input logic [2:0] funct3,
                                       input logic [1:0] offset);
        logic err;
        case (funct3)
            FunctB:  err = 1'b0;
            FunctH:  err = offset[0];
            FunctW:  err = |offset;
            FunctBu: err = write;
            FunctHu: err = write | offset[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and byte/half store merge
// into the word just read from memory.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] i_rd,
    input  logic [15:0]     i_wdata,
    input  logic [1:0]      i_offset,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_load_data,
    output logic [XLEN-1:0] o_merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;

    assign w_half   = i_offset[1] ? i_rd[31:16] : i_rd[15:0];
    assign w_signed = ~i_funct3[2];

    always_comb begin
        w_byte = i_rd[7:0];
        case (i_offset)
            2'd0:    w_byte = i_rd[7:0];
            2'd1:    w_byte = i_rd[15:8];
            2'd2:    w_byte = i_rd[23:16];
            default: w_byte = i_rd[31:24];
        endcase
    end

    always_comb begin
        o_load_data = i_rd;
        case (i_funct3[1:0])
            2'b00:   o_load_data = {{24{w_signed & w_byte[7]}}, w_byte};
            2'b01:   o_load_data = {{16{w_signed & w_half[15]}}, w_half};
            default: o_load_data = i_rd;
        endcase
    end

    always_comb begin
        o_merge_data = i_rd;
        if (i_funct3[1:0] == 2'b00) begin
            case (i_offset)
                2'd0:    o_merge_data[7:0]   = i_wdata[7:0];
                2'd1:    o_merge_data[15:8]  = i_wdata[7:0];
                2'd2:    o_merge_data[23:16] = i_wdata[7:0];
                default: o_merge_data[31:24] = i_wdata[7:0];
            endcase
        end else if (i_offset[1]) begin
            o_merge_data[31:16] = i_wdata;
        end else begin
            o_merge_data[15:0] = i_wdata;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, registered responses, and
// read-modify-write for sub-word stores on a memory without byte enables.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_error,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    input  logic [DATA_W-1:0]     rd
);

    logic [2:0]            r_state;
    logic [2:0]            r_funct3;
    logic [1:0]            r_offset;
    logic [DM_ADDRESS-1:0] r_a;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_merge;
    logic                  r_resp_valid;
    logic [DATA_W-1:0]     r_resp_rdata;
    logic                  r_resp_error;

    logic                  w_error;
    logic [DATA_W-1:0]     w_load_data;
    logic [DATA_W-1:0]     w_merge_data;
    logic [DATA_W-1:0]     w_wd;
    logic                  w_unused_addr;

    // Byte addresses wrap: upper address bits are deliberately dropped.
    assign w_unused_addr = ^req_addr[DATA_W-1:DM_ADDRESS+2];
    assign w_error       = req_error(req_write, req_funct3, req_addr[1:0]);

    lsu_align u_align (
        .i_rd         (rd),
        .i_wdata      (r_wdata[15:0]),
        .i_offset     (r_offset),
        .i_funct3     (r_funct3),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_funct3     <= '0;
            r_offset     <= '0;
            r_a          <= '0;
            r_wdata      <= '0;
            r_merge      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_error <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_funct3 <= req_funct3;
                        r_offset <= req_addr[1:0];
                        r_a      <= req_addr[DM_ADDRESS+1:2];
                        r_wdata  <= req_wdata;
                        if (w_error) begin
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                            r_resp_rdata <= '0;
                        end else if (!req_write) begin
                            r_state <= StLoad;
                        end else if (req_funct3 == FunctW) begin
                            r_state <= StWrite;
                        end else begin
                            r_state <= StRmwRead;
                        end
                    end
                end
                StLoad: begin
                    r_resp_valid <= 1'b1;
                    r_resp_error <= 1'b0;
                    r_resp_rdata <= w_load_data;
                    r_state      <= StIdle;
                end
                StRmwRead: begin
                    r_merge <= w_merge_data;
                    r_state <= StRmwWrite;
                end
                StWrite, StRmwWrite: begin
                    r_resp_valid <= 1'b1;
                    r_resp_error <= 1'b0;
                    r_resp_rdata <= '0;
                    r_state      <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        w_wd = '0;
        if (r_state == StWrite) begin
            w_wd = r_wdata;
        end else if (r_state == StRmwWrite) begin
            w_wd = r_merge;
        end
    end

    assign req_ready  = (r_state == StIdle);
    assign MemRead    = (r_state == StLoad) || (r_state == StRmwRead);
    assign MemWrite   = (r_state == StWrite) || (r_state == StRmwWrite);
    assign a          = r_a;
    assign wd         = w_wd;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_error = r_resp_error;

endmodule
